// File: rtl/reg_file_pkg.sv
// Shared defaults for the scoreboarded register file and its read ports.
// Every module of the register file imports this package.
package reg_file_pkg;

   localparam int RF_DW     = 32;
   localparam int RF_AW     = 5;
   localparam int RF_NR     = 2;
   localparam int RF_WPORTS = 2;

endpackage

// File: rtl/rf_read_port.sv
// One read port: write-through bypass of same-cycle writes plus operand-ready flag.
// Port 1 data shadows port 0 data when both write the address being read.
module rf_read_port
   import reg_file_pkg::*;
#(
   parameter int DW = RF_DW,
   parameter int AW = RF_AW
) (
   input  logic [AW-1:0]           ra_i,
   input  logic [RF_WPORTS-1:0]    we_i,
   input  logic [RF_WPORTS*AW-1:0] wa_i,
   input  logic [RF_WPORTS*DW-1:0] wd_i,
   input  logic [DW-1:0]           stored_i,
   input  logic                    busy_i,
   output logic [DW-1:0]           rd_o,
   output logic                    rrdy_o
);

   logic hit0;
   logic hit1;
   logic isZero;

   assign hit0   = we_i[0] && (wa_i[0 +: AW] == ra_i);
   assign hit1   = we_i[1] && (wa_i[AW +: AW] == ra_i);
   assign isZero = (ra_i == '0);

   // Entry 0 is hardwired to zero, so it wins over any bypass.
   always_comb begin
      rd_o = stored_i;
      if (isZero) begin
         rd_o = '0;
      end else if (hit1) begin
         rd_o = wd_i[DW +: DW];
      end else if (hit0) begin
         rd_o = wd_i[0 +: DW];
      end
   end

   assign rrdy_o = isZero || !busy_i || hit0 || hit1;

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, NR-read register file with a per-entry busy scoreboard.
// Reads bypass same-cycle writes; entry 0 is constant zero and never busy.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DW = RF_DW,
   parameter int AW = RF_AW,
   parameter int NR = RF_NR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [RF_WPORTS-1:0]    we,
   input  logic [RF_WPORTS*AW-1:0] wa,
   input  logic [RF_WPORTS*DW-1:0] wd,
   input  logic [NR*AW-1:0]        ra,
   output logic [NR*DW-1:0]        rd,
   output logic [NR-1:0]           rrdy,
   input  logic                    iss_v,
   input  logic [AW-1:0]           iss_a,
   output logic                    iss_ok,
   output logic [AW:0]             busy_cnt
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [AW:0]      busyCnt_q;
   logic [AW:0]      busyCnt_d;

   logic [AW-1:0] wa0;
   logic [AW-1:0] wa1;
   logic [DW-1:0] wd0;
   logic [DW-1:0] wd1;
   logic          issHit;
   logic          issAccept;

   assign wa0 = wa[0 +: AW];
   assign wa1 = wa[AW +: AW];
   assign wd0 = wd[0 +: DW];
   assign wd1 = wd[DW +: DW];

   // A write landing this cycle frees the destination, so it may be re-reserved at once.
   assign issHit    = (we[0] && (wa0 == iss_a)) || (we[1] && (wa1 == iss_a));
   assign iss_ok    = (iss_a == '0) || !busy_q[iss_a] || issHit;
   assign issAccept = iss_v && iss_ok && (iss_a != '0);

   // Writes retire reservations; an accepted issue applied last keeps its entry busy.
   always_comb begin
      busy_d = busy_q;
      if (we[0]) begin
         busy_d[wa0] = 1'b0;
      end
      if (we[1]) begin
         busy_d[wa1] = 1'b0;
      end
      if (issAccept) begin
         busy_d[iss_a] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Counting the next-state vector keeps busy_cnt aligned with the registered busy bits.
   always_comb begin
      busyCnt_d = '0;
      for (int j = 0; j < DEPTH; j++) begin
         busyCnt_d = busyCnt_d + (AW+1)'(busy_d[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= '0;
         busyCnt_q <= '0;
      end else begin
         busy_q    <= busy_d;
         busyCnt_q <= busyCnt_d;
      end
   end

   // Port 1 is written after port 0 so it takes the entry on an address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem_q[j] <= '0;
         end
      end else begin
         if (we[0] && (wa0 != '0)) begin
            mem_q[wa0] <= wd0;
         end
         if (we[1] && (wa1 != '0)) begin
            mem_q[wa1] <= wd1;
         end
      end
   end

   assign busy_cnt = busyCnt_q;

   for (genvar i = 0; i < NR; i++) begin : g_read
      logic [AW-1:0] raI;
      assign raI = ra[i*AW +: AW];

      rf_read_port #(
         .DW(DW),
         .AW(AW)
      ) u_port (
         .ra_i    (raI),
         .we_i    (we),
         .wa_i    (wa),
         .wd_i    (wd),
         .stored_i(mem_q[raI]),
         .busy_i  (busy_q[raI]),
         .rd_o    (rd[i*DW +: DW]),
         .rrdy_o  (rrdy[i])
      );
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed corner cases followed by random traffic,
// checked against an associative-array model of the register file and its busy set.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        we;
   logic [2*AW-1:0]   wa;
   logic [2*DW-1:0]   wd;
   logic [NR*AW-1:0]  ra;
   logic [NR*DW-1:0]  rd;
   logic [NR-1:0]     rrdy;
   logic              iss_v;
   logic [AW-1:0]     iss_a;
   logic              iss_ok;
   logic [AW:0]       busy_cnt;

   typedef struct {
      bit          rst;
      bit [1:0]    we;
      bit [AW-1:0] wa0;
      bit [AW-1:0] wa1;
      bit [DW-1:0] wd0;
      bit [DW-1:0] wd1;
      bit [AW-1:0] ra0;
      bit [AW-1:0] ra1;
      bit          issV;
      bit [AW-1:0] issA;
   } stim_t;

   typedef struct {
      logic [DW-1:0] rd0;
      logic [DW-1:0] rd1;
      logic [NR-1:0] rrdy;
      logic          issOk;
      logic [AW:0]   busyCnt;
      string         tag;
   } exp_t;

   exp_t        expQ[$];
   bit [DW-1:0] memM[int];
   bit          busyM[int];
   int          assertCount = 0;
   int          failCount   = 0;

   reg_file_sb #(
      .DW(DW),
      .AW(AW),
      .NR(NR)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wa      (wa),
      .wd      (wd),
      .ra      (ra),
      .rd      (rd),
      .rrdy    (rrdy),
      .iss_v   (iss_v),
      .iss_a   (iss_a),
      .iss_ok  (iss_ok),
      .busy_cnt(busy_cnt)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   function automatic bit writeHits(stim_t s, int a);
      return (s.we[0] && int'(s.wa0) == a) || (s.we[1] && int'(s.wa1) == a);
   endfunction

   // An operand is ready if it is the zero entry, unreserved, or being written right now.
   function automatic bit modelReady(stim_t s, int a);
      return (a == 0) || !busyM.exists(a) || writeHits(s, a);
   endfunction

   // Newest data wins: port 1 write, then port 0 write, then what is stored.
   function automatic bit [DW-1:0] modelRead(stim_t s, int a);
      if (a == 0) return '0;
      if (s.we[1] && int'(s.wa1) == a) return s.wd1;
      if (s.we[0] && int'(s.wa0) == a) return s.wd0;
      if (memM.exists(a)) return memM[a];
      return '0;
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, then advance the model.
   task automatic applyStimulus(input stim_t s, input bit check, input string tag);
      exp_t e;
      bit   accept;
      @(posedge clk);
      #1;
      rst   = s.rst;
      we    = s.we;
      wa    = {s.wa1, s.wa0};
      wd    = {s.wd1, s.wd0};
      ra    = {s.ra1, s.ra0};
      iss_v = s.issV;
      iss_a = s.issA;
      if (check) begin
         e.rd0     = modelRead(s, int'(s.ra0));
         e.rd1     = modelRead(s, int'(s.ra1));
         e.rrdy    = {modelReady(s, int'(s.ra1)), modelReady(s, int'(s.ra0))};
         e.issOk   = modelReady(s, int'(s.issA));
         e.busyCnt = (AW+1)'(busyM.num());
         e.tag     = tag;
         expQ.push_back(e);
      end
      accept = s.issV && modelReady(s, int'(s.issA)) && (s.issA != 0);
      if (s.rst) begin
         memM.delete();
         busyM.delete();
      end else begin
         if (s.we[0] && s.wa0 != 0) memM[int'(s.wa0)] = s.wd0;
         if (s.we[1] && s.wa1 != 0) memM[int'(s.wa1)] = s.wd1;
         if (s.we[0] && busyM.exists(int'(s.wa0))) busyM.delete(int'(s.wa0));
         if (s.we[1] && busyM.exists(int'(s.wa1))) busyM.delete(int'(s.wa1));
         if (accept) busyM[int'(s.issA)] = 1'b1;
      end
   endtask

   task automatic cmp(input string tag, input string name,
                      input logic [DW-1:0] act, input logic [DW-1:0] req);
      assertCount++;
      if (act !== req) begin
         failCount++;
         $display("[TB] FAIL %s/%s: got %h, expected %h", tag, name, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp(e.tag, "rd0",      rd[0 +: DW],            e.rd0);
      cmp(e.tag, "rd1",      rd[DW +: DW],           e.rd1);
      cmp(e.tag, "rrdy",     DW'(rrdy),              DW'(e.rrdy));
      cmp(e.tag, "iss_ok",   DW'(iss_ok),            DW'(e.issOk));
      cmp(e.tag, "busy_cnt", DW'(busy_cnt),          DW'(e.busyCnt));
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Directed corner cases, then random traffic with occasional resets.
   initial begin
      stim_t s;
      rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; iss_v = 1'b0; iss_a = '0;

      s = idle(); s.rst = 1'b1;
      applyStimulus(s, 0, "reset");
      applyStimulus(s, 0, "reset");
      s = idle(); s.ra0 = 3; s.ra1 = 17; s.issA = 9;
      applyStimulus(s, 1, "post_reset");

      // Dual-write collision on address 3.
      s = idle(); s.we = 2'b11; s.wa0 = 3; s.wa1 = 3;
      s.wd1 = 32'hAAAA0001; s.wd0 = 32'h55550000;
      applyStimulus(s, 1, "collide_wr");
      s = idle(); s.ra0 = 3;
      applyStimulus(s, 1, "collide_rd");

      // Same-cycle bypass.
      s = idle(); s.we = 2'b01; s.wa0 = 7; s.wd0 = 32'h12345678; s.ra0 = 7;
      applyStimulus(s, 1, "bypass");

      // Scoreboard reserve, blocked re-issue, release by write.
      s = idle(); s.issV = 1'b1; s.issA = 5; s.ra0 = 5;
      applyStimulus(s, 1, "sb_issue1");
      applyStimulus(s, 1, "sb_issue2");
      s = idle(); s.we = 2'b01; s.wa0 = 5; s.wd0 = 32'hCAFE0005; s.ra0 = 5; s.issA = 5;
      applyStimulus(s, 1, "sb_write");
      s = idle(); s.ra0 = 5;
      applyStimulus(s, 1, "sb_free");

      // Issue/write race on address 9.
      s = idle(); s.issV = 1'b1; s.issA = 9;
      applyStimulus(s, 1, "race_set");
      s = idle(); s.issV = 1'b1; s.issA = 9; s.we = 2'b10; s.wa1 = 9;
      s.wd1 = 32'h00000909; s.ra1 = 9;
      applyStimulus(s, 1, "race");
      s = idle(); s.ra0 = 9;
      applyStimulus(s, 1, "race_after");

      // Zero register ignores writes and reservations.
      s = idle(); s.we = 2'b11; s.wa0 = 0; s.wa1 = 0;
      s.wd0 = 32'hFFFFFFFF; s.wd1 = 32'hFFFFFFFF; s.issV = 1'b1; s.issA = 0;
      applyStimulus(s, 1, "zero_wr");
      s = idle(); s.we = 2'b01; s.wa0 = 9; s.issA = 0;
      applyStimulus(s, 1, "zero_rd");

      // Reset in the middle of activity.
      s = idle(); s.issV = 1'b1; s.issA = 2; s.we = 2'b01; s.wa0 = 10; s.wd0 = 32'h1010;
      applyStimulus(s, 1, "mid_a");
      s = idle(); s.issV = 1'b1; s.issA = 4; s.we = 2'b10; s.wa1 = 11; s.wd1 = 32'h1111;
      applyStimulus(s, 1, "mid_b");
      s = idle(); s.issV = 1'b1; s.issA = 6; s.ra0 = 10; s.ra1 = 11;
      applyStimulus(s, 1, "mid_c");
      s = idle(); s.rst = 1'b1; s.we = 2'b01; s.wa0 = 12; s.wd0 = 32'h1212;
      s.issV = 1'b1; s.issA = 13; s.ra0 = 2; s.ra1 = 4;
      applyStimulus(s, 1, "mid_rst");
      s = idle(); s.ra0 = 10; s.ra1 = 12; s.issA = 2;
      applyStimulus(s, 1, "mid_after");

      // Random traffic concentrated on a few addresses to provoke collisions.
      for (int n = 0; n < 1500; n++) begin
         s = idle();
         s.rst  = ($urandom_range(0, 79) == 0);
         s.we   = 2'($urandom_range(0, 3));
         s.wa0  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.wa1  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.wd0  = $urandom;
         s.wd1  = $urandom;
         s.ra0  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.ra1  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         s.issV = $urandom_range(0, 1) == 1;
         s.issA = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         applyStimulus(s, 1, "random");
      end

      repeat (3) @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; depth = 2**AW entries.
REQ-003 SHALL have parameter NR, default 2, number of read ports (1..4).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  2  write enable per write port; port 1 has higher priority than port 0.
- wa  in  2*AW  write addresses; port k occupies bits [k*AW +: AW].
- wd  in  2*DW  write data; port k occupies bits [k*DW +: DW].
- ra  in  NR*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd  out  NR*DW  read data; port i occupies bits [i*DW +: DW].
- rrdy  out  NR  read port i operand is valid, with no pending producer.
- iss_v  in  1  issue request; reserves destination iss_a.
- iss_a  in  AW  issue destination address.
- iss_ok  out  1  iss_a may be reserved this cycle.
- busy_cnt  out  AW+1  registered count of reserved entries.

Function
REQ-006 Entry 0 SHALL always read 0, SHALL ignore writes, and SHALL never be marked busy.
REQ-007 A write on port k with we[k]=1 and wa!=0 SHALL update the entry at the clock edge.
REQ-008 If both write ports target the same nonzero address in one cycle, the entry SHALL take the port-1 data.
REQ-009 rd[i] SHALL be combinational. Its value is selected in this order:
- ra[i]==0: 0;
- else, a same-cycle port-1 write to ra[i]: that port-1 data;
- else, a same-cycle port-0 write to ra[i]: that port-0 data;
- else: the stored value.
REQ-010 SHALL keep one busy bit per entry.
REQ-011 An accepted issue (iss_v && iss_ok && iss_a!=0) SHALL set busy[iss_a] at the next edge.
REQ-012 A write with we[k]=1 SHALL clear busy[wa[k]] at the next edge.
REQ-013 When an issue and a write target the same address in one cycle, the issue SHALL win and busy SHALL remain set.
REQ-014 iss_ok SHALL be 1 when any of the following holds:
- iss_a==0;
- busy[iss_a]==0;
- a same-cycle write targets iss_a.
Otherwise iss_ok SHALL be 0.
REQ-015 An issue with iss_ok=0 SHALL be ignored (no state change).
REQ-016 rrdy[i] SHALL be 1 when any of the following holds:
- ra[i]==0;
- busy[ra[i]]==0;
- a same-cycle write targets ra[i].
Otherwise rrdy[i] SHALL be 0.
REQ-017 busy_cnt SHALL equal the population count of the busy bits after each edge, with a 1-cycle latency.
REQ-018 busy_cnt SHALL never exceed 2**AW-1.
REQ-019 A write to an entry that is not busy SHALL still update the data and SHALL leave busy clear.

Reset
REQ-020 When rst=1 at a clock edge, all entries, all busy bits and busy_cnt SHALL become 0.
REQ-021 rst SHALL take priority over same-cycle writes and issues, including mid-operation.
REQ-022 In the cycle after reset, every rrdy bit SHALL be 1, iss_ok SHALL be 1, and every rd SHALL be 0, provided no writes are present.

Structure
REQ-023 The defaults for DW, AW and NR SHALL live in the shared package reg_file_pkg.
REQ-024 The per-read-port bypass and ready logic SHALL be a sub-module, rf_read_port, instantiated NR times.

Verification
REQ-025 Dual-write collision:
- stimulus: reset, then we=11, wa={3,3}, wd={0xAAAA0001, 0x55550000}; next cycle read ra0=3.
- required: rd0=0xAAAA0001.
REQ-026 Bypass:
- stimulus: write port 0 to addr 7 with 0x12345678 while ra0=7 in the same cycle.
- required: rd0=0x12345678 in that same cycle.
REQ-027 Scoreboard:
- stimulus: issue to 5; next cycle, issue to 5 again; then write addr 5.
- required:
  - after the first issue, rrdy with ra=5 is 0, busy_cnt=1, and iss_ok for 5 is 0;
  - during the write cycle, rrdy=1;
  - next cycle, busy_cnt=0.
REQ-028 Issue/write race:
- stimulus: with busy[9]=1, issue to 9 and write addr 9 in the same cycle.
- required: iss_ok=1, and next cycle busy[9]=1 with busy_cnt unchanged.
REQ-029 Zero register:
- stimulus: write 0xFFFFFFFF to addr 0 and issue to 0.
- required: rd=0, rrdy=1, busy_cnt=0.
REQ-030 Reset mid-operation:
- stimulus: with 3 entries busy and data stored, assert rst for one cycle together with a write.
- required: next cycle, all rd=0, busy_cnt=0, iss_ok=1.
